// File: rtl/lh_ootx_pkg.sv
// Shared definitions for the lighthouse OOTX frame decoder.
// Holds the decoder state encoding, the framing constants and the
// reflected CRC-32 byte-update helper.
package lh_ootx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LENGTH  = 2'd1,
    PAYLOAD = 2'd2,
    CRC     = 2'd3
  } ootx_state_t;

  localparam int          OOTX_PREAMBLE_ZEROS = 17;
  localparam logic [31:0] OOTX_CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] OOTX_CRC_INIT       = 32'hFFFFFFFF;
  localparam int          OOTX_LEN_W          = 16;

  // Reflected CRC-32 update for one byte, LSB of the byte first.
  function automatic logic [31:0] ootx_crc32_byte(input logic [31:0] crc_in,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ OOTX_CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ootx_crc32.sv
// Byte-wide CRC-32/IEEE register (reflected, init 0xFFFFFFFF).
// Ports:
//   CLK, RESET     core clock, async active-high reset (CRC -> init)
//   INIT           reload the register with the init value
//   BYTE_EN, BYTE  fold one byte into the register this cycle
//   CRC            current register value (not final-XORed)
module ootx_crc32 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INIT,
  input  logic        BYTE_EN,
  input  logic [7:0]  BYTE,
  output logic [31:0] CRC
);

  // CRC register: reload on INIT, otherwise fold in each enabled byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CRC <= lh_ootx_pkg::OOTX_CRC_INIT;
    end else if (INIT) begin
      CRC <= lh_ootx_pkg::OOTX_CRC_INIT;
    end else if (BYTE_EN) begin
      CRC <= lh_ootx_pkg::ootx_crc32_byte(CRC, BYTE);
    end else begin
      CRC <= CRC;
    end
  end

endmodule

// File: rtl/ootx_frame_decoder.sv
// OOTX frame decoder for one lighthouse base station.
// Hunts for the 17-zero preamble, strips the sync bit after each 16-bit
// word, decodes the little-endian payload length, streams payload bytes
// and checks the trailing CRC-32.
// Ports:
//   CLK, RESET              core clock, async active-high reset
//   BIT_VALID, BIT_IN       one OOTX bit per strobe (strobes >= 3 cycles apart)
//   FRAME_START             pulse: preamble found
//   PAYLOAD_LEN[15:0]       decoded length, held until next FRAME_START
//   BYTE_VALID, BYTE_DATA   one strobe per payload byte (pad byte dropped)
//   FRAME_DONE, CRC_OK      pulse at frame end; CRC_OK held until next FRAME_START
//   ERROR                   pulse: sync-bit violation or oversize length
module ootx_frame_decoder
  import lh_ootx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BIT_VALID,
  input  logic        BIT_IN,
  output logic        FRAME_START,
  output logic [15:0] PAYLOAD_LEN,
  output logic        BYTE_VALID,
  output logic [7:0]  BYTE_DATA,
  output logic        FRAME_DONE,
  output logic        CRC_OK,
  output logic        ERROR
);

  localparam logic [4:0]  ZERO_SAT = 5'(OOTX_PREAMBLE_ZEROS);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  ootx_state_t state_r, state_n;
  logic [4:0]  zero_cnt_r, zero_cnt_n;
  logic [4:0]  bit_idx_r, bit_idx_n;
  logic [15:0] shift_r, shift_n;
  logic [15:0] words_left_r, words_left_n;
  logic        crc_word_r, crc_word_n;
  logic [15:0] w0_r, w0_n;
  logic        lo_pend_r, lo_pend_n;
  logic [7:0]  lo_byte_r, lo_byte_n;
  logic [OOTX_LEN_W-1:0] len_n;
  logic        frame_start_n, byte_valid_n, frame_done_n, crc_ok_n, error_n;
  logic [7:0]  byte_data_n;
  logic [15:0] word_s, len_dec_s;
  logic [31:0] rx_crc_s, crc_val;

  // Emitted bytes feed the CRC in the cycle they appear on BYTE_VALID.
  ootx_crc32 u_crc (
    .CLK     (CLK),
    .RESET   (RESET),
    .INIT    (FRAME_START),
    .BYTE_EN (BYTE_VALID),
    .BYTE    (BYTE_DATA),
    .CRC     (crc_val)
  );

  // Next-state and output decode for the hunt / word-collector FSM.
  always_comb begin
    state_n       = state_r;
    zero_cnt_n    = zero_cnt_r;
    bit_idx_n     = bit_idx_r;
    shift_n       = shift_r;
    words_left_n  = words_left_r;
    crc_word_n    = crc_word_r;
    w0_n          = w0_r;
    lo_byte_n     = lo_byte_r;
    lo_pend_n     = 1'b0;
    len_n         = PAYLOAD_LEN;
    frame_start_n = 1'b0;
    byte_valid_n  = 1'b0;
    byte_data_n   = BYTE_DATA;
    frame_done_n  = 1'b0;
    crc_ok_n      = CRC_OK;
    error_n       = 1'b0;
    word_s        = {shift_r[14:0], BIT_IN};
    len_dec_s     = {word_s[7:0], word_s[15:8]};
    rx_crc_s      = {word_s[7:0], word_s[15:8], w0_r[7:0], w0_r[15:8]};

    // Second byte of a payload word goes out the cycle after the first.
    if (lo_pend_r) begin
      byte_valid_n = 1'b1;
      byte_data_n  = lo_byte_r;
    end else begin
      byte_valid_n = 1'b0;
    end

    if (BIT_VALID) begin
      case (state_r)
        HUNT: begin
          if (!BIT_IN) begin
            if (zero_cnt_r < ZERO_SAT) begin
              zero_cnt_n = zero_cnt_r + 5'd1;
            end else begin
              zero_cnt_n = zero_cnt_r;
            end
          end else if (zero_cnt_r >= ZERO_SAT) begin
            state_n       = LENGTH;
            zero_cnt_n    = 5'd0;
            bit_idx_n     = 5'd0;
            frame_start_n = 1'b1;
            crc_ok_n      = 1'b0;
            len_n         = 16'd0;
          end else begin
            zero_cnt_n = 5'd0;
          end
        end
        LENGTH, PAYLOAD, CRC: begin
          if (bit_idx_r == 5'd16) begin
            if (!BIT_IN) begin
              // A bad sync bit may itself be the first preamble zero.
              error_n    = 1'b1;
              state_n    = HUNT;
              zero_cnt_n = 5'd1;
            end else begin
              bit_idx_n = 5'd0;
              if (state_r == LENGTH) begin
                state_n    = (PAYLOAD_LEN == 16'd0) ? CRC : PAYLOAD;
                crc_word_n = 1'b0;
              end else if ((state_r == PAYLOAD) && (words_left_r == 16'd0)) begin
                state_n    = CRC;
                crc_word_n = 1'b0;
              end else begin
                state_n = state_r;
              end
            end
          end else begin
            shift_n   = word_s;
            bit_idx_n = bit_idx_r + 5'd1;
            if (bit_idx_r == 5'd15) begin
              case (state_r)
                LENGTH: begin
                  len_n        = len_dec_s;
                  words_left_n = 16'((17'(len_dec_s) + 17'd1) >> 1);
                  if (len_dec_s > MAX_LEN) begin
                    error_n    = 1'b1;
                    state_n    = HUNT;
                    zero_cnt_n = 5'd0;
                  end else begin
                    state_n = LENGTH;
                  end
                end
                PAYLOAD: begin
                  byte_valid_n = 1'b1;
                  byte_data_n  = word_s[15:8];
                  lo_byte_n    = word_s[7:0];
                  words_left_n = words_left_r - 16'd1;
                  // Odd length: the last word's low byte is padding.
                  lo_pend_n    = !((words_left_r == 16'd1) && PAYLOAD_LEN[0]);
                end
                CRC: begin
                  if (!crc_word_r) begin
                    w0_n       = word_s;
                    crc_word_n = 1'b1;
                  end else begin
                    // Second CRC word carries no sync bit; finish now.
                    frame_done_n = 1'b1;
                    crc_ok_n     = (~crc_val == rx_crc_s);
                    state_n      = HUNT;
                    zero_cnt_n   = 5'd0;
                  end
                end
                default: begin
                  state_n = HUNT;
                end
              endcase
            end else begin
              state_n = state_r;
            end
          end
        end
        default: begin
          state_n    = HUNT;
          zero_cnt_n = 5'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State and registered-output update.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= HUNT;
      zero_cnt_r   <= 5'd0;
      bit_idx_r    <= 5'd0;
      shift_r      <= 16'd0;
      words_left_r <= 16'd0;
      crc_word_r   <= 1'b0;
      w0_r         <= 16'd0;
      lo_pend_r    <= 1'b0;
      lo_byte_r    <= 8'd0;
      FRAME_START  <= 1'b0;
      PAYLOAD_LEN  <= 16'd0;
      BYTE_VALID   <= 1'b0;
      BYTE_DATA    <= 8'd0;
      FRAME_DONE   <= 1'b0;
      CRC_OK       <= 1'b0;
      ERROR        <= 1'b0;
    end else begin
      state_r      <= state_n;
      zero_cnt_r   <= zero_cnt_n;
      bit_idx_r    <= bit_idx_n;
      shift_r      <= shift_n;
      words_left_r <= words_left_n;
      crc_word_r   <= crc_word_n;
      w0_r         <= w0_n;
      lo_pend_r    <= lo_pend_n;
      lo_byte_r    <= lo_byte_n;
      FRAME_START  <= frame_start_n;
      PAYLOAD_LEN  <= len_n;
      BYTE_VALID   <= byte_valid_n;
      BYTE_DATA    <= byte_data_n;
      FRAME_DONE   <= frame_done_n;
      CRC_OK       <= crc_ok_n;
      ERROR        <= error_n;
    end
  end

endmodule

// File: tb/tb_ootx_frame_decoder.sv
// Self-checking bench for ootx_frame_decoder: builds OOTX frames from byte
// lists, computes the expected CRC bit-serially, and checks the decoded
// stream, length, CRC result and error pulses.
module tb_ootx_frame_decoder;

  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BIT_VALID;
  logic        BIT_IN;
  logic        FRAME_START;
  logic [15:0] PAYLOAD_LEN;
  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        FRAME_DONE;
  logic        CRC_OK;
  logic        ERROR;

  int tests = 0;
  int fails = 0;
  int fs_cnt = 0, fd_cnt = 0, err_cnt = 0, clash_cnt = 0;
  logic [7:0] byte_q[$];

  always #5 CLK = ~CLK;

  ootx_frame_decoder #(.MAX_PAYLOAD(64)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BIT_VALID   (BIT_VALID),
    .BIT_IN      (BIT_IN),
    .FRAME_START (FRAME_START),
    .PAYLOAD_LEN (PAYLOAD_LEN),
    .BYTE_VALID  (BYTE_VALID),
    .BYTE_DATA   (BYTE_DATA),
    .FRAME_DONE  (FRAME_DONE),
    .CRC_OK      (CRC_OK),
    .ERROR       (ERROR)
  );

  // Event monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (FRAME_START) fs_cnt++;
    if (FRAME_DONE) fd_cnt++;
    if (ERROR) err_cnt++;
    if (FRAME_START && ERROR) clash_cnt++;
    if (BYTE_VALID) byte_q.push_back(BYTE_DATA);
  end

  // Reference CRC-32/IEEE, computed one bit at a time.
  function automatic logic [31:0] ref_crc(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ d[i][k]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic send_bit(input logic b);
    @(posedge CLK); #1;
    BIT_VALID = 1'b1; BIT_IN = b;
    @(posedge CLK); #1;
    BIT_VALID = 1'b0; BIT_IN = 1'($urandom_range(0, 1));
    repeat ($urandom_range(2, 4)) @(posedge CLK);
  endtask

  task automatic send_word(input logic [15:0] w, input logic with_sync, input logic sync_val);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    if (with_sync) send_bit(sync_val);
  endtask

  task automatic send_preamble();
    repeat ($urandom_range(0, 2)) send_bit(1'b1);
    repeat (17 + $urandom_range(0, 3)) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  // Length word, payload words (pad 0x00 if odd), two CRC words.
  task automatic send_body(input bq_t pl, input logic [15:0] len, input logic [31:0] crc);
    int nw;
    logic [7:0] lo;
    nw = (int'(len) + 1) / 2;
    send_word({len[7:0], len[15:8]}, 1'b1, 1'b1);
    for (int i = 0; i < nw; i++) begin
      lo = (2 * i + 1 < int'(len)) ? pl[2 * i + 1] : 8'h00;
      send_word({pl[2 * i], lo}, 1'b1, 1'b1);
    end
    send_word({crc[7:0], crc[15:8]}, 1'b1, 1'b1);
    send_word({crc[23:16], crc[31:24]}, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
  endtask

  function automatic bq_t digits();
    bq_t q;
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    return q;
  endfunction

  task automatic test_reset();
    RESET = 1'b1; BIT_VALID = 1'b0; BIT_IN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests++;
    if ({FRAME_START, PAYLOAD_LEN, BYTE_VALID, BYTE_DATA, FRAME_DONE, CRC_OK, ERROR} !== 29'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0",
               {FRAME_START, PAYLOAD_LEN, BYTE_VALID, BYTE_DATA, FRAME_DONE, CRC_OK, ERROR});
    end
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_clean_frame();
    bq_t pl;
    int fs0, fd0, er0, bq0;
    pl = digits();
    fs0 = fs_cnt; fd0 = fd_cnt; er0 = err_cnt; bq0 = byte_q.size();
    send_preamble();
    send_body(pl, 16'd9, 32'hCBF43926);
    tests++; if (fs_cnt - fs0 != 1) begin fails++; $display("FAIL clean_start: got %0d want 1", fs_cnt - fs0); end
    tests++; if (PAYLOAD_LEN !== 16'd9) begin fails++; $display("FAIL clean_len: got %0d want 9", PAYLOAD_LEN); end
    tests++; if (byte_q.size() - bq0 != 9) begin fails++; $display("FAIL clean_count: got %0d want 9", byte_q.size() - bq0); end
    for (int i = 0; i < 9 && bq0 + i < byte_q.size(); i++) begin
      tests++;
      if (byte_q[bq0 + i] !== pl[i]) begin fails++; $display("FAIL clean_byte%0d: got %h want %h", i, byte_q[bq0 + i], pl[i]); end
    end
    tests++; if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL clean_done: got %0d want 1", fd_cnt - fd0); end
    tests++; if (CRC_OK !== 1'b1) begin fails++; $display("FAIL clean_crc_ok: got %b want 1", CRC_OK); end
    tests++; if (err_cnt - er0 != 0) begin fails++; $display("FAIL clean_err: got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_bitflip();
    bq_t pl;
    int fd0, er0, bq0;
    pl = digits();
    pl[4] = pl[4] ^ 8'h01;
    fd0 = fd_cnt; er0 = err_cnt; bq0 = byte_q.size();
    send_preamble();
    send_body(pl, 16'd9, 32'hCBF43926);
    tests++; if (byte_q.size() - bq0 != 9) begin fails++; $display("FAIL flip_count: got %0d want 9", byte_q.size() - bq0); end
    tests++; if (bq0 + 4 < byte_q.size() && byte_q[bq0 + 4] !== 8'h34) begin fails++; $display("FAIL flip_byte: got %h want 34", byte_q[bq0 + 4]); end
    tests++; if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL flip_done: got %0d want 1", fd_cnt - fd0); end
    tests++; if (CRC_OK !== 1'b0) begin fails++; $display("FAIL flip_crc_ok: got %b want 0", CRC_OK); end
    tests++; if (err_cnt - er0 != 0) begin fails++; $display("FAIL flip_err: got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_len_zero();
    bq_t pl;
    int fd0, bq0;
    fd0 = fd_cnt; bq0 = byte_q.size();
    send_preamble();
    send_body(pl, 16'd0, 32'h00000000);
    tests++; if (byte_q.size() - bq0 != 0) begin fails++; $display("FAIL zero_bytes: got %0d want 0", byte_q.size() - bq0); end
    tests++; if (PAYLOAD_LEN !== 16'd0) begin fails++; $display("FAIL zero_len: got %0d want 0", PAYLOAD_LEN); end
    tests++; if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL zero_done: got %0d want 1", fd_cnt - fd0); end
    tests++; if (CRC_OK !== 1'b1) begin fails++; $display("FAIL zero_crc_ok: got %b want 1", CRC_OK); end
  endtask

  task automatic test_sync_error();
    bq_t pl;
    int fs0, fd0, er0;
    pl = digits();
    fd0 = fd_cnt; er0 = err_cnt;
    send_preamble();
    send_word(16'h0900, 1'b1, 1'b1);
    send_word(16'h3132, 1'b1, 1'b1);
    send_word(16'h3334, 1'b1, 1'b0);
    tests++; if (err_cnt - er0 != 1) begin fails++; $display("FAIL sync_err: got %0d want 1", err_cnt - er0); end
    tests++; if (fd_cnt - fd0 != 0) begin fails++; $display("FAIL sync_nodone: got %0d want 0", fd_cnt - fd0); end
    fs0 = fs_cnt;
    repeat (16) send_bit(1'b0);
    send_bit(1'b1);
    tests++; if (fs_cnt - fs0 != 1) begin fails++; $display("FAIL sync_restart: got %0d want 1", fs_cnt - fs0); end
    send_body(pl, 16'd9, 32'hCBF43926);
    tests++; if (fd_cnt - fd0 != 1 || CRC_OK !== 1'b1) begin fails++; $display("FAIL sync_recover: got done=%0d ok=%b want 1/1", fd_cnt - fd0, CRC_OK); end
  endtask

  task automatic test_oversize();
    int er0, bq0, fd0;
    er0 = err_cnt; bq0 = byte_q.size(); fd0 = fd_cnt;
    send_preamble();
    send_word(16'h4100, 1'b1, 1'b1);
    send_word(16'h3132, 1'b1, 1'b1);
    tests++; if (err_cnt - er0 != 1) begin fails++; $display("FAIL over_err: got %0d want 1", err_cnt - er0); end
    tests++; if (byte_q.size() - bq0 != 0) begin fails++; $display("FAIL over_bytes: got %0d want 0", byte_q.size() - bq0); end
    tests++; if (fd_cnt - fd0 != 0) begin fails++; $display("FAIL over_done: got %0d want 0", fd_cnt - fd0); end
  endtask

  task automatic test_reset_mid();
    bq_t pl;
    int fd0, er0;
    pl = digits();
    fd0 = fd_cnt; er0 = err_cnt;
    send_preamble();
    send_word(16'h0900, 1'b1, 1'b1);
    send_word(16'h3132, 1'b1, 1'b1);
    send_word(16'h3334, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if ({FRAME_START, PAYLOAD_LEN, BYTE_VALID, BYTE_DATA, FRAME_DONE, CRC_OK, ERROR} !== 29'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h want 0",
               {FRAME_START, PAYLOAD_LEN, BYTE_VALID, BYTE_DATA, FRAME_DONE, CRC_OK, ERROR});
    end
    RESET = 1'b0;
    tests++; if (fd_cnt - fd0 != 0 || err_cnt - er0 != 0) begin fails++; $display("FAIL midreset_events: got done=%0d err=%0d want 0/0", fd_cnt - fd0, err_cnt - er0); end
    send_preamble();
    send_body(pl, 16'd9, 32'hCBF43926);
    tests++; if (fd_cnt - fd0 != 1 || CRC_OK !== 1'b1 || PAYLOAD_LEN !== 16'd9) begin
      fails++; $display("FAIL midreset_recover: got done=%0d ok=%b len=%0d want 1/1/9", fd_cnt - fd0, CRC_OK, PAYLOAD_LEN);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      bq_t pl;
      int len, fd0, er0, bq0;
      logic [31:0] c;
      logic corrupt;
      len = (f == 0) ? 64 : int'($urandom_range(0, 64));
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      corrupt = ($urandom_range(0, 2) == 0);
      c = ref_crc(pl);
      if (corrupt) c = c ^ (32'd1 << $urandom_range(0, 31));
      fd0 = fd_cnt; er0 = err_cnt; bq0 = byte_q.size();
      send_preamble();
      send_body(pl, 16'(len), c);
      tests++; if (PAYLOAD_LEN !== 16'(len)) begin fails++; $display("FAIL rnd%0d_len: got %0d want %0d", f, PAYLOAD_LEN, len); end
      tests++; if (byte_q.size() - bq0 != len) begin fails++; $display("FAIL rnd%0d_count: got %0d want %0d", f, byte_q.size() - bq0, len); end
      for (int i = 0; i < len && bq0 + i < byte_q.size(); i++) begin
        tests++;
        if (byte_q[bq0 + i] !== pl[i]) begin fails++; $display("FAIL rnd%0d_byte%0d: got %h want %h", f, i, byte_q[bq0 + i], pl[i]); end
      end
      tests++; if (fd_cnt - fd0 != 1 || err_cnt - er0 != 0) begin fails++; $display("FAIL rnd%0d_events: got done=%0d err=%0d want 1/0", f, fd_cnt - fd0, err_cnt - er0); end
      tests++; if (CRC_OK !== !corrupt) begin fails++; $display("FAIL rnd%0d_crc_ok: got %b want %b", f, CRC_OK, !corrupt); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_bitflip();
    test_len_zero();
    test_sync_error();
    test_oversize();
    test_reset_mid();
    test_random_frames();
    tests++;
    if (clash_cnt != 0) begin fails++; $display("FAIL start_error_clash: got %0d want 0", clash_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
